// File: rtl/rv_pkg.sv
// Shared definitions for the Risc-V-FPGA front end: default width, the
// canonical NOP encoding and the redirect-priority encoding.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_DECODE = 2'd1,
    REDIR_EXEC   = 2'd2
  } redir_sel_e;

  // The older instruction (Execute/Memory) wins over a Decode prediction.
  function automatic redir_sel_e redir_select(input logic em_correct, input logic d_predict);
    redir_sel_e sel;
    sel = REDIR_NONE;
    if (em_correct) sel = REDIR_EXEC;
    else if (d_predict) sel = REDIR_DECODE;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the prefetch queue and the
// in-flight PC tracker. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Fetch stage with a prefetch queue between instruction memory and Decode.
// Define PREFETCH_PERF_EN to add the fetched/discarded response counters.
module prefetch_unit import rv_pkg::*; #(
  parameter int              XLEN            = rv_pkg::XLEN,
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            F_stall_i,
  input  logic            D_flush_i,
  input  logic            D_predictPC_i,
  input  logic [XLEN-1:0] D_PCprediction_i,
  input  logic            EM_correctPC_i,
  input  logic [XLEN-1:0] EM_PCcorrection_i,
  output logic            IMemReq_o,
  output logic [XLEN-1:0] IMemAddr_o,
  input  logic            IMemRdy_i,
  input  logic            IMemValid_i,
  input  logic [XLEN-1:0] IMemData_i,
  output logic [XLEN-1:0] FD_PC_o,
  output logic [XLEN-1:0] FD_instr_o,
  output logic            FD_nop_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_discarded_o
`endif
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int SW = CW + 1;

  redir_sel_e        redir_sel;
  logic              redirect;
  logic [XLEN-1:0]   redir_target;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d, discard_q, discard_d;
  logic [SW-1:0]     pending;
  logic              accept, resp_valid, resp_push, q_pop;
  logic [CW-1:0]     q_count, pc_count;
  logic              q_empty, q_full, pc_empty, pc_full;
  logic [2*XLEN-1:0] q_rdata;
  logic [XLEN-1:0]   resp_pc;
  logic              fd_nop_q, fd_nop_d;
  logic [XLEN-1:0]   fd_pc_q, fd_pc_d, fd_instr_q, fd_instr_d;
  logic              unused_flags;

  assign unused_flags = ^{q_full, pc_full, pc_count, pc_empty};

  always_comb begin
    redir_sel = redir_select(EM_correctPC_i, D_predictPC_i);
    redirect  = (redir_sel != REDIR_NONE);
    case (redir_sel)
      REDIR_EXEC:   redir_target = EM_PCcorrection_i;
      REDIR_DECODE: redir_target = D_PCprediction_i;
      default:      redir_target = fetch_pc_q;
    endcase
    IMemAddr_o = redirect ? redir_target : fetch_pc_q;
    // Queue slots are reserved for every in-flight request, so pushes never overflow.
    pending    = SW'(outstanding_q) + SW'(discard_q);
    IMemReq_o  = !reset_i && ((SW'(q_count) + pending) < SW'(QDEPTH))
                 && (pending < SW'(MAX_OUTSTANDING));
    accept     = IMemReq_o && IMemRdy_i;
    resp_valid = IMemValid_i && !reset_i;
    resp_push  = resp_valid && !redirect && (discard_q == '0);
    q_pop      = !reset_i && !F_stall_i && !D_flush_i && !redirect && !q_empty;

    fetch_pc_d = fetch_pc_q;
    if (accept) fetch_pc_d = IMemAddr_o + XLEN'(4);
    else if (redirect) fetch_pc_d = redir_target;

    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect) begin
      // The response arriving now belongs to the old stream either way.
      discard_d     = discard_q + outstanding_q - CW'(resp_valid);
      outstanding_d = CW'(accept);
    end else begin
      if (resp_valid) begin
        if (discard_q != '0) discard_d = discard_q - 1'b1;
        else outstanding_d = outstanding_q - 1'b1;
      end
      if (accept) outstanding_d = outstanding_d + 1'b1;
    end

    fd_nop_d   = fd_nop_q;
    fd_pc_d    = fd_pc_q;
    fd_instr_d = fd_instr_q;
    if (D_flush_i || redirect) begin
      fd_nop_d = 1'b1;
    end else if (!F_stall_i) begin
      if (!q_empty) begin
        fd_nop_d   = 1'b0;
        fd_pc_d    = q_rdata[2*XLEN-1:XLEN];
        fd_instr_d = q_rdata[XLEN-1:0];
      end else begin
        fd_nop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fd_nop_q      <= 1'b1;
      fd_pc_q       <= '0;
      fd_instr_q    <= XLEN'(NOP_INSTR);
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fd_nop_q      <= fd_nop_d;
      fd_pc_q       <= fd_pc_d;
      fd_instr_q    <= fd_instr_d;
    end
  end

  assign FD_PC_o    = fd_pc_q;
  assign FD_instr_o = fd_instr_q;
  assign FD_nop_o   = fd_nop_q;

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(QDEPTH)) u_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (resp_push),
    .pop_i   (q_pop),
    .flush_i (redirect),
    .data_i  ({resp_pc, IMemData_i}),
    .data_o  (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Holds the address of every accepted request until its response returns.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_inflight_pc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (accept),
    .pop_i   (resp_valid),
    .flush_i (1'b0),
    .data_i  (IMemAddr_o),
    .data_o  (resp_pc),
    .count_o (pc_count),
    .empty_o (pc_empty),
    .full_o  (pc_full)
  );

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_discarded_q, perf_discarded_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(resp_push);
    perf_discarded_d = perf_discarded_q + 32'(resp_valid && !resp_push);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched_o   = perf_fetched_q;
  assign perf_discarded_o = perf_discarded_q;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios then random traffic, checked
// against a transaction-level model of memory, prefetch queue and FD register.
module tb_prefetch_unit;

  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam int          MAXO     = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            reset_i, F_stall_i, D_flush_i, D_predictPC_i, EM_correctPC_i;
  logic [XLEN-1:0] D_PCprediction_i, EM_PCcorrection_i;
  logic            IMemReq_o, IMemRdy_i, IMemValid_i;
  logic [XLEN-1:0] IMemAddr_o, IMemData_i;
  logic [XLEN-1:0] FD_PC_o, FD_instr_o;
  logic            FD_nop_o;
`ifdef PREFETCH_PERF_EN
  logic [31:0]     perf_fetched_o, perf_discarded_o;
`endif

  prefetch_unit #(
    .XLEN(XLEN), .QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .F_stall_i         (F_stall_i),
    .D_flush_i         (D_flush_i),
    .D_predictPC_i     (D_predictPC_i),
    .D_PCprediction_i  (D_PCprediction_i),
    .EM_correctPC_i    (EM_correctPC_i),
    .EM_PCcorrection_i (EM_PCcorrection_i),
    .IMemReq_o         (IMemReq_o),
    .IMemAddr_o        (IMemAddr_o),
    .IMemRdy_i         (IMemRdy_i),
    .IMemValid_i       (IMemValid_i),
    .IMemData_i        (IMemData_i),
    .FD_PC_o           (FD_PC_o),
    .FD_instr_o        (FD_instr_o),
    .FD_nop_o          (FD_nop_o)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_fetched_o    (perf_fetched_o),
    .perf_discarded_o  (perf_discarded_o)
`endif
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- scoreboard / model state ----
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];   // accepted requests awaiting response, in order
  logic [63:0] exp_q[$];   // {pc, instr} expected to reach Decode, in order
  logic [31:0] m_next_pc, m_fd_pc, m_fd_instr;
  logic        m_fd_nop;
  int          cyc, lat, last_due, m_fetched, m_dropped;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0] ^ 16'h0013};
  endfunction

  // ---- driver: one clock cycle of stimulus, model update and checks ----
  task automatic cycle(input logic rst, input logic stall, input logic flush,
                       input logic dp, input logic [31:0] dt,
                       input logic ep, input logic [31:0] et, input logic rdy);
    logic        exp_req, redir, resp, pop;
    logic [31:0] exp_addr, tgt;
    logic [63:0] e;
    mreq_t       r;
    @(negedge clk);
    reset_i = rst; F_stall_i = stall; D_flush_i = flush;
    D_predictPC_i = dp; D_PCprediction_i = dt;
    EM_correctPC_i = ep; EM_PCcorrection_i = et;
    IMemRdy_i = rdy;
    resp = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    IMemValid_i = resp;
    IMemData_i  = resp ? mem_word(mem_q[0].addr) : $urandom();
    redir    = ep || dp;
    tgt      = ep ? et : dt;
    exp_req  = !rst && ((exp_q.size() + mem_q.size()) < QDEPTH) && (mem_q.size() < MAXO);
    exp_addr = redir ? tgt : m_next_pc;
    #1;
    check("imem_req", IMemReq_o, exp_req);
    if (!rst && exp_req) check("imem_addr", IMemAddr_o, exp_addr);

    @(posedge clk);
    if (rst) begin
      mem_q.delete(); exp_q.delete();
      m_next_pc = RESET_PC; m_fd_nop = 1'b1; m_fd_pc = '0; m_fd_instr = 32'h0000_0013;
      m_fetched = 0; m_dropped = 0; last_due = 0;
    end else begin
      pop = !stall && !flush && !redir && (exp_q.size() > 0);
      if (resp) r = mem_q.pop_front();
      if (redir) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        if (resp) m_dropped++;
        m_fd_nop = 1'b1;
      end else begin
        if (flush) m_fd_nop = 1'b1;
        else if (!stall) begin
          if (pop) begin
            e = exp_q.pop_front();
            m_fd_nop = 1'b0; m_fd_pc = e[63:32]; m_fd_instr = e[31:0];
          end else m_fd_nop = 1'b1;
        end
        if (resp) begin
          if (r.stale) m_dropped++;
          else begin
            exp_q.push_back({r.addr, mem_word(r.addr)});
            m_fetched++;
          end
        end
      end
      if (exp_req && rdy) begin
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
        mem_q.push_back('{addr: exp_addr, due: last_due, stale: 1'b0});
        m_next_pc = exp_addr + 32'd4;
      end else if (redir) m_next_pc = tgt;
    end
    cyc++;
    #1;
    check("fd_nop", FD_nop_o, m_fd_nop);
    check("fd_pc", FD_PC_o, m_fd_pc);
    check("fd_instr", FD_instr_o, m_fd_instr);
`ifdef PREFETCH_PERF_EN
    check("perf_fetched", perf_fetched_o, m_fetched);
    check("perf_discarded", perf_discarded_o, m_dropped);
`endif
  endtask

  task automatic run(input int n, input logic stall, input logic rdy);
    repeat (n) cycle(1'b0, stall, 1'b0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  // ---- sequence ----
  initial begin
    reset_i = 1'b1; F_stall_i = 1'b0; D_flush_i = 1'b0;
    D_predictPC_i = 1'b0; D_PCprediction_i = '0;
    EM_correctPC_i = 1'b0; EM_PCcorrection_i = '0;
    IMemRdy_i = 1'b0; IMemValid_i = 1'b0; IMemData_i = '0;
    cyc = 0; lat = 1; last_due = 0; m_fetched = 0; m_dropped = 0;
    m_next_pc = RESET_PC; m_fd_nop = 1'b1; m_fd_pc = '0; m_fd_instr = 32'h0000_0013;

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    run(20, 1'b0, 1'b1);                       // streaming, 1-cycle memory
    run(10, 1'b1, 1'b1);                       // stall: queue fills, requests stop
    run(10, 1'b0, 1'b1);
    lat = 3;
    run(6, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1);   // correction with work in flight
    run(15, 1'b0, 1'b1);
    lat = 1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1); // simultaneous redirects
    run(8, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)                // memory not ready, bubble in the middle
      cycle(1'b0, 1'b0, (i == 2), 1'b0, '0, 1'b0, '0, 1'b0);
    run(5, 1'b0, 1'b1);
    run(8, 1'b1, 1'b1);                        // fill queue, then reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    run(10, 1'b0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      cycle(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 4), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
            ($urandom_range(0, 99) < 3), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
            ($urandom_range(0, 99) < 75));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised successor fetch stage for the Risc-V-FPGA pipeline. It decouples instruction memory from the Decode unit with a prefetch queue of configurable depth. It tolerates variable-latency, in-order instruction memory with a request/response handshake, and applies Decode predictions and Execute/Memory corrections by flushing queued and in-flight fetches. It sits between the instruction memory port and the FD pipeline register consumed by Decode.

## Interface
- XLEN, 32: address/instruction width.
- QDEPTH, 4: prefetch queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered memory requests, ≤ QDEPTH.
- RESET_PC, 32'h0: fetch address after reset.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- F_stall_i  in  1  hold FD outputs; queue keeps filling.
- D_flush_i  in  1  next FD entry is a bubble.
- D_predictPC_i  in  1  Decode redirect request.
- D_PCprediction_i  in  XLEN  Decode redirect target.
- EM_correctPC_i  in  1  Execute/Memory redirect request.
- EM_PCcorrection_i  in  XLEN  Execute/Memory redirect target.
- IMemReq_o  out  1  request valid.
- IMemAddr_o  out  XLEN  request address.
- IMemRdy_i  in  1  memory accepts request this cycle.
- IMemValid_i  in  1  response valid; responses in request order.
- IMemData_i  in  XLEN  response instruction.
- FD_PC_o  out  XLEN  PC of the instruction presented to Decode.
- FD_instr_o  out  XLEN  instruction presented to Decode.
- FD_nop_o  out  1  FD entry is a bubble.

## Operation
- Redirect priority: EM_correctPC_i over D_predictPC_i (older instruction wins). Redirect target = chosen PC.
- IMemAddr_o = redirect target when a redirect is active, else the fetch PC register (combinational, same cycle).
- IMemReq_o = !reset_i && (queue count + outstanding + discard count) < QDEPTH && outstanding + discard < MAX_OUTSTANDING.
- Handshake: request accepted when IMemReq_o && IMemRdy_i. Fetch PC <= IMemAddr_o + 4 on accept; on a redirect without accept, fetch PC <= target. The address must stay stable while IMemReq_o is high and not accepted, unless a redirect occurs.
- Accepted requests increment outstanding. Each IMemValid_i decrements the discard counter if nonzero, otherwise pushes {PC, data} into the queue. PC is tracked by a parallel in-flight PC FIFO.
- On redirect: queue cleared, outstanding moved into the discard counter, and any response arriving that same cycle is dropped. A request accepted in the redirect cycle belongs to the new stream.
- FD update when !F_stall_i: if the queue is non-empty, pop to FD_PC_o/FD_instr_o with FD_nop_o=0; if empty, FD_nop_o=1 and FD_PC_o/FD_instr_o hold.
- FD_nop_o forced to 1 every cycle that D_flush_i, a redirect, or reset_i is high, regardless of F_stall_i. No pop occurs in that cycle.
- Queue full cannot overflow, because credits are reserved at request time.

## Timing
- Reset values: FD_nop_o=1, FD_PC_o=0, FD_instr_o=32'h00000013, fetch PC=RESET_PC, queue, outstanding and discard all 0, IMemReq_o=0 while reset_i is high.
- First request is issued the cycle after reset deasserts, at RESET_PC.
- Minimum latency: response in cycle N → FD valid at edge ending cycle N+1 (one cycle through the queue). Push and pop in the same cycle are allowed.
- Redirect in cycle N with immediate IMemRdy_i: target is requested in cycle N; with 1-cycle memory, Decode sees the target instruction at the end of N+2.
- Reset mid-operation discards everything; stale responses after reset are not counted. Memory must be reset with the unit.

## Configuration
- PREFETCH_PERF_EN defined: adds outputs perf_fetched_o (32b, responses pushed) and perf_discarded_o (32b, responses dropped). Both are reset to 0 and wrap on overflow.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `rv_pkg`: NOP_INSTR = 32'h00000013, XLEN default, and the redirect-priority encoding.
- Sub-module `fetch_fifo`: synchronous FIFO (width, depth parameters; push, pop, flush, count, empty, full). It is instantiated for the prefetch queue and for the in-flight PC FIFO.

## Test plan
- Reset, then 1-cycle memory always ready → FD shows PC 0,4,8,… with FD_nop_o=0 from the third cycle; instr matches memory.
- F_stall_i held 10 cycles with QDEPTH=4 → exactly 4 responses are queued, IMemReq_o drops, and FD holds its value. Release → PCs continue with no gap or duplicate.
- Memory latency 3, EM_correctPC_i to 0x100 with 3 outstanding → 3 responses dropped and the next FD PC is 0x100 (perf_discarded_o=3 with PREFETCH_PERF_EN).
- D_predictPC_i=0x40 and EM_correctPC_i=0x80 in the same cycle → IMemAddr_o=0x80; the 0x40 fetch is never issued.
- IMemRdy_i low for 5 cycles → IMemAddr_o stays stable and FD_nop_o=1 once the queue drains; D_flush_i in that cycle → bubble.
- reset_i asserted with a full queue → FD_nop_o=1 the next cycle and the first request goes to RESET_PC.
